// File: rtl/sfu_pkg.sv
// Shared constants and FSM state encoding for the SFU accumulator sequencer,
// SFU bank and core controller.
package sfu_pkg;

    localparam int unsigned SFU_ADDR_NUM = 16;
    localparam int unsigned SFU_SEL_W    = 4;
    localparam int unsigned SFU_KIJ_W    = 4;

    typedef logic [2:0] sfu_state_t;

    localparam sfu_state_t ST_IDLE  = 3'd0;
    localparam sfu_state_t ST_CLEAR = 3'd1;
    localparam sfu_state_t ST_ACC   = 3'd2;
    localparam sfu_state_t ST_DRAIN = 3'd3;
    localparam sfu_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/sfu_addr_cnt.sv
// Modulo-ADDR_NUM slot counter with a wrap pulse; shared by the accumulate
// pass and the readout sweep.
module sfu_addr_cnt #(
    parameter int unsigned ADDR_NUM = 16,
    parameter int unsigned SEL_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [SEL_W-1:0] o_cnt,
    output logic [SEL_W-1:0] o_nxt,
    output logic             o_wrap
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(ADDR_NUM - 1);

    logic [SEL_W-1:0] r_cnt;

    always_comb begin
        o_nxt = (r_cnt == LAST) ? '0 : r_cnt + SEL_W'(1);
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = i_inc && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_nxt;
        end
    end

endmodule

// File: rtl/sfu_acc_ctrl.sv
// SFU accumulator sequencer: clear, accumulate num_kij passes from the ofifo,
// then sweep the bank for readout. Optional ReLU strobe via SFU_RELU_EN.
module sfu_acc_ctrl
    import sfu_pkg::*;
#(
    parameter int unsigned ADDR_NUM = SFU_ADDR_NUM,
    parameter int unsigned SEL_W    = SFU_SEL_W,
    parameter int unsigned KIJ_W    = SFU_KIJ_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KIJ_W-1:0] num_kij,
    input  logic             ofifo_valid,
    output logic             ofifo_rd,
    output logic             acc,
    output logic             clr,
    output logic [SEL_W-1:0] sel_line,
    output logic             rd_out,
    output logic             relu_en,
    output logic             busy,
    output logic             done
);

    sfu_state_t       r_state;
    sfu_state_t       w_state_nxt;
    logic [KIJ_W-1:0] r_kij_tgt;
    logic [KIJ_W-1:0] r_kij;
    logic             r_pop_done;
    logic [SEL_W-1:0] r_pop_sel;
    logic             r_ofifo_rd;
    logic             r_acc;
    logic             r_clr;
    logic [SEL_W-1:0] r_sel;
    logic             r_rd_out;
    logic             r_busy;
    logic             r_done;

    logic             w_pop;
    logic             w_enter_drain;
    logic             w_drain_step;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic [SEL_W-1:0] w_cnt;
    logic [SEL_W-1:0] w_cnt_nxt;
    logic             w_cnt_wrap;

    assign w_pop         = (r_state == ST_ACC) && !r_pop_done && ofifo_valid;
    // Wait for the last pop's acc to go out before the readout sweep starts.
    assign w_enter_drain = (r_state == ST_ACC) && r_pop_done && !r_ofifo_rd;
    assign w_drain_step  = (r_state == ST_DRAIN) && !w_cnt_wrap;
    assign w_cnt_inc     = w_pop || (r_state == ST_DRAIN);
    assign w_cnt_clr     = (r_state == ST_CLEAR) || w_enter_drain;

    sfu_addr_cnt #(
        .ADDR_NUM (ADDR_NUM),
        .SEL_W    (SEL_W)
    ) u_addr_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_cnt  (w_cnt),
        .o_nxt  (w_cnt_nxt),
        .o_wrap (w_cnt_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_ACC;
            ST_ACC:   if (w_enter_drain) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_cnt_wrap) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_kij_tgt  <= '0;
            r_kij      <= '0;
            r_pop_done <= 1'b0;
            r_pop_sel  <= '0;
            r_ofifo_rd <= 1'b0;
            r_acc      <= 1'b0;
            r_clr      <= 1'b0;
            r_sel      <= '0;
            r_rd_out   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_clr      <= (r_state == ST_IDLE) && start;
            r_done     <= (r_state == ST_DRAIN) && w_cnt_wrap;
            r_ofifo_rd <= w_pop;
            r_acc      <= r_ofifo_rd;
            r_rd_out   <= w_enter_drain || w_drain_step;

            if (w_pop) begin
                r_pop_sel <= w_cnt;
            end

            if (r_ofifo_rd) begin
                r_sel <= r_pop_sel;
            end else if (w_enter_drain) begin
                r_sel <= '0;
            end else if (w_drain_step) begin
                r_sel <= w_cnt_nxt;
            end

            if ((r_state == ST_IDLE) && start) begin
                r_kij_tgt <= (num_kij == '0) ? KIJ_W'(1) : num_kij;
            end

            if (r_state == ST_CLEAR) begin
                r_kij      <= '0;
                r_pop_done <= 1'b0;
            end else if ((r_state == ST_ACC) && w_cnt_wrap) begin
                if (r_kij == r_kij_tgt - KIJ_W'(1)) begin
                    r_pop_done <= 1'b1;
                end else begin
                    r_kij <= r_kij + KIJ_W'(1);
                end
            end
        end
    end

`ifdef SFU_RELU_EN
    logic r_relu_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_relu_en <= 1'b0;
        end else begin
            r_relu_en <= w_enter_drain || w_drain_step;
        end
    end

    assign relu_en = r_relu_en;
`else
    assign relu_en = 1'b0;
`endif

    assign ofifo_rd = r_ofifo_rd;
    assign acc      = r_acc;
    assign clr      = r_clr;
    assign sel_line = r_sel;
    assign rd_out   = r_rd_out;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
